// File: rtl/br_output_checker_pkg.sv
// ---------------------------------------------------------------------------
// br_tb_defs
// Shared definitions for the output checker: default address/data widths
// and the checker FSM state encoding.
// ---------------------------------------------------------------------------
package br_tb_defs;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/br_abs_diff_cmp.sv
// ---------------------------------------------------------------------------
// br_abs_diff_cmp
// Combinational tolerance compare: o_exceed = |i_a - i_b| > i_tol, computed
// unsigned on W+1 bits so the full 0..2^W-1 difference is representable.
// Ports:
//   i_a, i_b  [W-1:0]  samples to compare
//   i_tol     [W:0]    maximum allowed absolute difference
//   o_exceed           difference is larger than tolerance
// ---------------------------------------------------------------------------
module br_abs_diff_cmp
    import br_tb_defs::*;
#(
    parameter int W = DATA_W_DEF
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic [W:0]   i_tol,
    output logic         o_exceed
);

    logic [W:0] w_a;
    logic [W:0] w_b;
    logic [W:0] w_diff;

    always_comb begin
        w_a      = {1'b0, i_a};
        w_b      = {1'b0, i_b};
        w_diff   = (w_a >= w_b) ? (w_a - w_b) : (w_b - w_a);
        o_exceed = (w_diff > i_tol);
    end

endmodule

// File: rtl/br_output_checker.sv
// ---------------------------------------------------------------------------
// br_output_checker
// Streams DUT output samples against a golden memory and reports the result.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | after reset, no run started yet
//   ST_RUN  | run in progress, accepting one sample per valid beat
//   ST_DONE | run finished, results held until next start or reset
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_start               pulse: begin a run (ignored while running)
//   i_base_addr           golden address of the first expected sample
//   i_num_outputs         number of samples to check (0 = finish at once)
//   i_dut_valid/i_dut_data  DUT sample stream
//   o_dut_ready           high in ST_RUN
//   o_gold_addr/i_gold_data combinational golden-memory read
//   o_busy, o_done, o_pass  run status
//   o_mismatch_count      saturating count of failing samples
//   o_first_err_valid/o_first_err_addr  first failing golden address
//   o_extra_sample        sticky: sample offered while not running
// ---------------------------------------------------------------------------
module br_output_checker
    import br_tb_defs::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int TOL    = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [ADDR_W-1:0] i_num_outputs,
    input  logic              i_dut_valid,
    input  logic [DATA_W-1:0] i_dut_data,
    output logic              o_dut_ready,
    output logic [ADDR_W-1:0] o_gold_addr,
    input  logic [DATA_W-1:0] i_gold_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_pass,
    output logic [ADDR_W-1:0] o_mismatch_count,
    output logic              o_first_err_valid,
    output logic [ADDR_W-1:0] o_first_err_addr,
    output logic              o_extra_sample
);

    localparam logic [DATA_W:0] TOL_V = (DATA_W+1)'(TOL);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_gold_addr;
    logic [ADDR_W-1:0] r_remaining;
    logic [ADDR_W-1:0] r_mismatch_count;
    logic [ADDR_W-1:0] r_first_err_addr;
    logic              r_first_err_valid;
    logic              r_extra_sample;
    logic              w_exceed;
    logic              w_beat;
    logic              w_last_beat;
    logic              w_start_ok;
    logic              w_run_nonzero;

    br_abs_diff_cmp #(.W(DATA_W)) u_cmp (
        .i_a      (i_dut_data),
        .i_b      (i_gold_data),
        .i_tol    (TOL_V),
        .o_exceed (w_exceed)
    );

    always_comb begin
        w_start_ok    = i_start && (r_state != ST_RUN);
        w_run_nonzero = (i_num_outputs != '0);
        w_beat        = (r_state == ST_RUN) && i_dut_valid;
        w_last_beat   = w_beat && (r_remaining == ADDR_W'(1));
        w_state_nxt   = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    w_state_nxt = w_run_nonzero ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (w_last_beat) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state           <= ST_IDLE;
            r_gold_addr       <= '0;
            r_remaining       <= '0;
            r_mismatch_count  <= '0;
            r_first_err_valid <= 1'b0;
            r_first_err_addr  <= '0;
            r_extra_sample    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start_ok) begin
                // A sample arriving together with start belongs to no run,
                // so clearing takes precedence over the sticky extra flag.
                r_mismatch_count  <= '0;
                r_first_err_valid <= 1'b0;
                r_first_err_addr  <= '0;
                r_extra_sample    <= 1'b0;
                if (w_run_nonzero) begin
                    r_gold_addr <= i_base_addr;
                    r_remaining <= i_num_outputs;
                end
            end else begin
                if (w_beat) begin
                    r_gold_addr <= r_gold_addr + ADDR_W'(1);
                    r_remaining <= r_remaining - ADDR_W'(1);
                    if (w_exceed) begin
                        if (r_mismatch_count != '1) begin
                            r_mismatch_count <= r_mismatch_count + ADDR_W'(1);
                        end
                        if (!r_first_err_valid) begin
                            r_first_err_valid <= 1'b1;
                            r_first_err_addr  <= r_gold_addr;
                        end
                    end
                end
                if (i_dut_valid && (r_state != ST_RUN)) begin
                    r_extra_sample <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        o_dut_ready       = (r_state == ST_RUN);
        o_busy            = (r_state == ST_RUN);
        o_done            = (r_state == ST_DONE);
        o_pass            = o_done && (r_mismatch_count == '0) && !r_extra_sample;
        o_gold_addr       = r_gold_addr;
        o_mismatch_count  = r_mismatch_count;
        o_first_err_valid = r_first_err_valid;
        o_first_err_addr  = r_first_err_addr;
        o_extra_sample    = r_extra_sample;
    end

endmodule

// File: tb/tb_br_output_checker.sv
// ---------------------------------------------------------------------------
// tb_br_output_checker
// Two checker instances (TOL=0 and TOL=1) share one stimulus stream and one
// golden memory; expectations come from fixed vectors and a reference model
// that counts failing samples with integer arithmetic.
// ---------------------------------------------------------------------------
module tb_br_output_checker;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] base_addr;
    logic [15:0] num_outputs;
    logic        dut_valid;
    logic [7:0]  dut_data;

    logic        ready0, busy0, done0, pass0, fv0, extra0;
    logic [15:0] gaddr0, cnt0, fa0;
    logic [7:0]  gdata0;
    logic        ready1, busy1, done1, pass1, fv1, extra1;
    logic [15:0] gaddr1, cnt1, fa1;
    logic [7:0]  gdata1;

    logic [7:0]  gmem [0:65535];
    logic [7:0]  dq [$];

    int n_checks;
    int n_errors;
    int m_cnt [2];
    bit m_fv [2];
    logic [15:0] m_fa [2];

    assign gdata0 = gmem[gaddr0];
    assign gdata1 = gmem[gaddr1];

    br_output_checker #(.ADDR_W(16), .DATA_W(8), .TOL(0)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_base_addr(base_addr),
        .i_num_outputs(num_outputs), .i_dut_valid(dut_valid), .i_dut_data(dut_data),
        .o_dut_ready(ready0), .o_gold_addr(gaddr0), .i_gold_data(gdata0),
        .o_busy(busy0), .o_done(done0), .o_pass(pass0), .o_mismatch_count(cnt0),
        .o_first_err_valid(fv0), .o_first_err_addr(fa0), .o_extra_sample(extra0)
    );

    br_output_checker #(.ADDR_W(16), .DATA_W(8), .TOL(1)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_base_addr(base_addr),
        .i_num_outputs(num_outputs), .i_dut_valid(dut_valid), .i_dut_data(dut_data),
        .o_dut_ready(ready1), .o_gold_addr(gaddr1), .i_gold_data(gdata1),
        .o_busy(busy1), .o_done(done1), .o_pass(pass1), .o_mismatch_count(cnt1),
        .o_first_err_valid(fv1), .o_first_err_addr(fa1), .o_extra_sample(extra1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Sample fails when the absolute difference exceeds the tolerance.
    function automatic bit is_bad(input logic [7:0] g, input logic [7:0] d, input int tol);
        int diff;
        diff = int'(d) - int'(g);
        if (diff < 0) diff = -diff;
        return diff > tol;
    endfunction

    task automatic check_reset(input string tag);
        chk({tag, "_busy"},  busy0,  0);
        chk({tag, "_ready"}, ready0, 0);
        chk({tag, "_done"},  done0,  0);
        chk({tag, "_pass"},  pass0,  0);
        chk({tag, "_cnt"},   cnt0,   0);
        chk({tag, "_fv"},    fv0,    0);
        chk({tag, "_fa"},    fa0,    0);
        chk({tag, "_extra"}, extra0, 0);
        chk({tag, "_addr"},  gaddr0, 0);
        chk({tag, "_done1"}, done1,  0);
        chk({tag, "_addr1"}, gaddr1, 0);
    endtask

    // Runs one check sequence using dq as the DUT byte stream; gap idle cycles
    // are inserted before every beat but the first, poke fires a start mid-run.
    task automatic do_run(input logic [15:0] base, input int n, input int gap, input bit poke);
        logic [15:0] a;
        for (int t = 0; t < 2; t++) begin
            m_cnt[t] = 0;
            m_fv[t]  = 1'b0;
            m_fa[t]  = 16'h0;
        end
        base_addr   = base;
        num_outputs = 16'(n);
        start       = 1'b1;
        tick();
        start = 1'b0;
        if (n == 0) begin
            chk("zero_done", done0, 1);
            chk("zero_busy", busy0, 0);
            return;
        end
        chk("start_busy",  busy0,  1);
        chk("start_ready", ready0, 1);
        chk("start_done",  done0,  0);
        for (int k = 0; k < n; k++) begin
            a = 16'(base + 16'(k));
            if (k > 0) begin
                for (int j = 0; j < gap; j++) begin
                    dut_valid = 1'b0;
                    tick();
                    chk("stall_addr", gaddr0, a);
                    chk("stall_busy", busy0, 1);
                end
            end
            chk("beat_addr0", gaddr0, a);
            chk("beat_addr1", gaddr1, a);
            dut_valid = 1'b1;
            dut_data  = dq[k];
            if (poke && k == n / 2) begin
                start       = 1'b1;
                base_addr   = ~base;
                num_outputs = 16'd1;
            end
            for (int t = 0; t < 2; t++) begin
                if (is_bad(gmem[a], dq[k], t)) begin
                    m_cnt[t]++;
                    if (!m_fv[t]) begin
                        m_fv[t] = 1'b1;
                        m_fa[t] = a;
                    end
                end
            end
            tick();
            start     = 1'b0;
            dut_valid = 1'b0;
            chk("run_cnt0", cnt0, m_cnt[0]);
            chk("run_cnt1", cnt1, m_cnt[1]);
            chk("run_fv0",  fv0,  m_fv[0]);
            chk("run_fa0",  fa0,  m_fa[0]);
            chk("run_fv1",  fv1,  m_fv[1]);
            chk("run_fa1",  fa1,  m_fa[1]);
            if (k < n - 1) chk("early_done", done0, 0);
        end
        chk("end_done0", done0, 1);
        chk("end_done1", done1, 1);
        chk("end_busy",  busy0, 0);
        chk("end_ready", ready0, 0);
        chk("end_addr",  gaddr0, 16'(base + 16'(n)));
    endtask

    typedef struct {
        logic [15:0]      base;
        int               n;
        logic [3:0][7:0]  g;
        logic [3:0][7:0]  d;
        int               gap;
        int               cnt0;
        bit               fv0;
        logic [15:0]      fa0;
        bit               pass0;
        int               cnt1;
        bit               fv1;
        logic [15:0]      fa1;
        bit               pass1;
    } vec_t;

    vec_t vt [5];

    initial begin
        logic [15:0] rb;
        logic [15:0] ra;
        logic [7:0]  rg;
        int          rn;

        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 65536; i++) gmem[i] = 8'h00;

        vt[0] = '{16'h0040, 4, {8'hBB, 8'h8A, 8'h9D, 8'h33}, {8'hBB, 8'h8A, 8'h9D, 8'h33}, 0,
                  0, 1'b0, 16'h0000, 1'b1, 0, 1'b0, 16'h0000, 1'b1};
        vt[1] = '{16'h0040, 4, {8'hBB, 8'h8A, 8'h9D, 8'h33}, {8'hBB, 8'h8B, 8'h9D, 8'h33}, 0,
                  1, 1'b1, 16'h0042, 1'b0, 0, 1'b0, 16'h0000, 1'b1};
        vt[2] = '{16'hFFFF, 2, {8'h00, 8'h00, 8'h95, 8'h95}, {8'h00, 8'h00, 8'h95, 8'h95}, 0,
                  0, 1'b0, 16'h0000, 1'b1, 0, 1'b0, 16'h0000, 1'b1};
        vt[3] = '{16'h1000, 4, {8'h00, 8'h30, 8'h20, 8'h10}, {8'hFF, 8'h2E, 8'h20, 8'h12}, 1,
                  3, 1'b1, 16'h1000, 1'b0, 3, 1'b1, 16'h1000, 1'b0};
        vt[4] = '{16'h2000, 4, {8'hFF, 8'h00, 8'h81, 8'h80}, {8'hFF, 8'h00, 8'h80, 8'h81}, 2,
                  2, 1'b1, 16'h2000, 1'b0, 0, 1'b0, 16'h0000, 1'b1};

        rst         = 1'b1;
        start       = 1'b0;
        base_addr   = 16'h0;
        num_outputs = 16'h0;
        dut_valid   = 1'b0;
        dut_data    = 8'h0;
        tick();
        tick();
        rst = 1'b0;
        check_reset("por");

        // Sample offered while idle is flagged, not compared.
        dut_valid = 1'b1;
        dut_data  = 8'hAA;
        tick();
        dut_valid = 1'b0;
        chk("idle_extra", extra0, 1);
        chk("idle_pass",  pass0,  0);
        chk("idle_cnt",   cnt0,   0);
        chk("idle_addr",  gaddr0, 0);

        // Fixed vectors.
        for (int v = 0; v < 5; v++) begin
            dq.delete();
            for (int i = 0; i < vt[v].n; i++) begin
                gmem[16'(vt[v].base + 16'(i))] = vt[v].g[i];
                dq.push_back(vt[v].d[i]);
            end
            do_run(vt[v].base, vt[v].n, vt[v].gap, 1'b0);
            chk("vec_cnt0",  cnt0,   vt[v].cnt0);
            chk("vec_fv0",   fv0,    vt[v].fv0);
            chk("vec_fa0",   fa0,    vt[v].fa0);
            chk("vec_pass0", pass0,  vt[v].pass0);
            chk("vec_cnt1",  cnt1,   vt[v].cnt1);
            chk("vec_fv1",   fv1,    vt[v].fv1);
            chk("vec_fa1",   fa1,    vt[v].fa1);
            chk("vec_pass1", pass1,  vt[v].pass1);
            chk("vec_extra", extra0, 0);
            tick();
        end

        // Empty run, then a stray sample while done.
        dq.delete();
        do_run(16'h0500, 0, 0, 1'b0);
        chk("zero_pass", pass0, 1);
        chk("zero_cnt",  cnt0,  0);
        chk("zero_extra", extra0, 0);
        dut_valid = 1'b1;
        dut_data  = 8'h11;
        tick();
        dut_valid = 1'b0;
        chk("done_extra",  extra0, 1);
        chk("done_pass",   pass0,  0);
        chk("done_held",   done0,  1);
        tick();
        chk("done_held2",  done0,  1);
        chk("extra_held",  extra1, 1);

        // Reset in the middle of a run with gapped beats.
        dq.delete();
        for (int i = 0; i < 8; i++) begin
            gmem[16'h0300 + 16'(i)] = 8'($urandom);
            dq.push_back(gmem[16'h0300 + 16'(i)]);
        end
        dq[0] = dq[0] ^ 8'h01;
        base_addr   = 16'h0300;
        num_outputs = 16'd8;
        start       = 1'b1;
        tick();
        start = 1'b0;
        for (int b = 0; b < 3; b++) begin
            dut_valid = 1'b1;
            dut_data  = dq[b];
            tick();
            dut_valid = 1'b0;
            if (b == 0) chk("mid_cnt", cnt0, 1);
            tick();
        end
        chk("mid_addr", gaddr0, 16'h0303);
        chk("mid_busy", busy0, 1);
        rst       = 1'b1;
        start     = 1'b1;
        dut_valid = 1'b1;
        tick();
        rst       = 1'b0;
        start     = 1'b0;
        dut_valid = 1'b0;
        check_reset("abort");
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_nodone", done0, 0);
            chk("abort_nobusy", busy0, 0);
        end
        gmem[16'h0310] = 8'h5A;
        dq.delete();
        dq.push_back(8'h5A);
        do_run(16'h0310, 1, 0, 1'b0);
        chk("after_abort_pass", pass0, 1);
        chk("after_abort_cnt",  cnt0,  0);

        // Randomized runs against the reference model.
        for (int r = 0; r < 25; r++) begin
            rb = (r % 5 == 0) ? 16'(16'hFFFF - 16'($urandom_range(0, 4))) : 16'($urandom);
            rn = $urandom_range(1, 12);
            dq.delete();
            for (int i = 0; i < rn; i++) begin
                ra = 16'(rb + 16'(i));
                rg = 8'($urandom);
                gmem[ra] = rg;
                case ($urandom_range(0, 3))
                    0, 1:    dq.push_back(rg);
                    2:       dq.push_back(($urandom_range(0, 1) == 0) ? 8'(rg + 8'd1) : 8'(rg - 8'd1));
                    default: dq.push_back(8'($urandom));
                endcase
            end
            do_run(rb, rn, $urandom_range(0, 2), ($urandom_range(0, 3) == 0));
            chk("rnd_pass0", pass0, (m_cnt[0] == 0));
            chk("rnd_pass1", pass1, (m_cnt[1] == 0));
            chk("rnd_extra", extra0, 0);
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/br_output_checker.md
BR_OUTPUT_CHECKER -- requirements
Module: br_output_checker

Interface
REQ-001 Parameter ADDR_W, default 16, golden-memory address width.
REQ-002 Parameter DATA_W, default 8, output sample width.
REQ-003 Parameter TOL, default 0, maximum allowed unsigned |dut - golden| per sample.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  single-cycle pulse that begins a check run.
REQ-007 base_addr  input  ADDR_W  golden address of the first expected sample.
REQ-008 num_outputs  input  ADDR_W  number of samples to check; sampled with start.
REQ-009 dut_valid  input  1  DUT output sample valid.
REQ-010 dut_data  input  DATA_W  DUT output sample.
REQ-011 dut_ready  output  1  checker accepts a sample this cycle.
REQ-012 gold_addr  output  ADDR_W  address to the golden output memory (combinational read).
REQ-013 gold_data  input  DATA_W  golden byte at gold_addr, same cycle.
REQ-014 busy  output  1  run in progress.
REQ-015 done  output  1  run finished; held until next start or rst.
REQ-016 pass  output  1  valid when done: zero mismatches and no extra samples.
REQ-017 mismatch_count  output  ADDR_W  failing samples in current run, saturating.
REQ-018 first_err_valid / first_err_addr  output  1 / ADDR_W  capture of first failing golden address.
REQ-019 extra_sample  output  1  sticky: dut_valid seen while not RUN.

Function
REQ-020 FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-021 IDLE/DONE + start with num_outputs != 0 -> RUN next cycle; counters, first_err, extra_sample, done cleared; gold_addr <= base_addr; remaining <= num_outputs.
REQ-022 IDLE/DONE + start with num_outputs == 0 -> DONE next cycle with pass=1, mismatch_count=0.
REQ-023 start while in RUN is ignored.
REQ-024 dut_ready = 1 exactly in RUN; beat accepted when dut_valid && dut_ready.
REQ-025 Per accepted beat: mismatch iff |dut_data - gold_data| > TOL, computed unsigned on DATA_W+1 bits; gold_addr increments by 1 with modulo-2^ADDR_W wrap (0xFFFF -> 0x0000); remaining decrements.
REQ-026 mismatch_count increments the cycle after a failing beat, saturates at all-ones.
REQ-027 first failing beat latches first_err_addr = gold_addr of that beat, first_err_valid=1; later failures do not overwrite.
REQ-028 Beat with remaining == 1 -> DONE next cycle; done=1 and pass, mismatch_count final in that same cycle (latency 1 from last beat).
REQ-029 dut_valid=0 in RUN stalls: no address, count or state change; no timeout.
REQ-030 dut_valid=1 in IDLE or DONE sets extra_sample; sample not compared; pass forced 0 while extra_sample=1.
REQ-031 busy = (state == RUN); gold_addr holds its last value outside RUN.

Reset
REQ-032 rst has priority over start and dut_valid: state IDLE, busy=0, done=0, pass=0, mismatch_count=0, first_err_valid=0, first_err_addr=0, extra_sample=0, gold_addr=0, remaining=0.
REQ-033 rst during RUN aborts the run; no done pulse; next start begins a fresh run.

Structure
REQ-034 Shared package/header br_tb_defs holds ADDR_W, DATA_W defaults and the IDLE/RUN/DONE state encodings.
REQ-035 Tolerance compare is a combinational sub-module br_abs_diff_cmp (inputs a, b, tol; output exceed).

Verification
REQ-036 Golden 0x40..0x43 = 33,9D,8A,BB; start base=0x40 n=4, DUT sends same bytes back-to-back -> done 1 cycle after 4th beat, pass=1, count=0.
REQ-037 Same run, DUT byte 2 = 0x8B, TOL=0 -> count=1, first_err_addr=0x42, pass=0; with TOL=1 -> pass=1.
REQ-038 base=0xFFFF n=2, golden[FFFF]=95, golden[0000]=95, DUT 95,95 -> gold_addr wraps to 0x0000, pass=1.
REQ-039 n=0 start -> done next cycle, pass=1; then dut_valid pulse in DONE -> extra_sample=1, pass=0.
REQ-040 n=8 with dut_valid gaps every other cycle, rst asserted after 3 beats -> all outputs at reset values, no done; new start n=1 completes normally.
